// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   FWD_*           2-bit forwarding-mux codes driven on fwd_rs1_sel / fwd_rs2_sel
//   hz_state_t      sequencer states
//   shadow_stage_t  one in-flight destination record {vld, rd, wen, is_load}
//   stage_hit()     true when a shadow stage produces the register a source reads
package core_pkg;

    localparam int RIDX_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic              vld;
        logic [RIDX_W-1:0] rd;
        logic              wen;
        logic              is_load;
    } shadow_stage_t;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic stage_hit(shadow_stage_t s, logic [RIDX_W-1:0] rs, logic use_rs);
        return s.vld & s.wen & (s.rd != '0) & (s.rd == rs) & use_rs;
    endfunction

endpackage

// File: rtl/hz_fwd_sel.sv
// Forwarding priority select for one source operand.
//   ex_s/mem_s/wb_s  shadow records of the instructions in EX, MEM and WB
//   rs, use_rs       source index read by the ID instruction and its read enable
//   sel              mux code: EX > MEM > WB, else register file
//   ex_load_hit      the youngest producer is a load still in EX (load-use hazard)
module hz_fwd_sel
    import core_pkg::*;
(
    input  shadow_stage_t     ex_s,
    input  shadow_stage_t     mem_s,
    input  shadow_stage_t     wb_s,
    input  logic [RIDX_W-1:0] rs,
    input  logic              use_rs,
    output logic [1:0]        sel,
    output logic              ex_load_hit
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        ex_hit      = stage_hit(ex_s, rs, use_rs);
        mem_hit     = stage_hit(mem_s, rs, use_rs);
        wb_hit      = stage_hit(wb_s, rs, use_rs);
        ex_load_hit = ex_hit & ex_s.is_load;
        sel         = FWD_RF;
        // A load in EX has no data yet; the ID instruction is stalled, so the
        // mux value is irrelevant and older stages must not be picked either.
        if (ex_hit) begin
            sel = ex_s.is_load ? FWD_RF : FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencer for the 5-stage core, sitting beside ID.
// Tracks destinations in flight (EX/MEM/WB shadow), selects operand forwarding,
// inserts load-use bubbles, freezes on memory back-pressure and squashes IF/ID on redirect.
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   id_*                     decoded fields of the instruction currently in ID
//   ex_redirect              taken branch/jump resolved in EX this cycle
//   mem_busy                 data memory not ready, whole pipe holds
//   stall_if, stall_id       hold PC/IF-ID and hold ID
//   bubble_ex, flush_ifid    load NOP into ID/EX, invalidate IF/ID
//   fwd_rs1_sel, fwd_rs2_sel operand forwarding mux codes
module pipe_hazard_ctl
    import core_pkg::*;
#(
    parameter int REG_W    = RIDX_W,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_ifid,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel
);

    localparam int CNT_W = 2;

    hz_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic          redirect_pend, pend_d;
    logic          resume_ls, resume_ls_d;
    shadow_stage_t ex_q, mem_q, wb_q;
    shadow_stage_t id_stage;
    logic          ld_hit1, ld_hit2;
    logic          load_use;

    hz_fwd_sel u_fwd_rs1 (
        .ex_s        (ex_q),
        .mem_s       (mem_q),
        .wb_s        (wb_q),
        .rs          (id_rs1),
        .use_rs      (id_use_rs1),
        .sel         (fwd_rs1_sel),
        .ex_load_hit (ld_hit1)
    );

    hz_fwd_sel u_fwd_rs2 (
        .ex_s        (ex_q),
        .mem_s       (mem_q),
        .wb_s        (wb_q),
        .rs          (id_rs2),
        .use_rs      (id_use_rs2),
        .sel         (fwd_rs2_sel),
        .ex_load_hit (ld_hit2)
    );

    assign load_use = id_valid & (ld_hit1 | ld_hit2);

    // cnt holds the bubbles still owed after the current cycle. The detection
    // cycle in RUN is already the first bubble, so LOAD_STALL is only entered
    // when LOAD_LAT > 1 and leaves once its last owed bubble has been issued.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pend_d      = redirect_pend;
        resume_ls_d = resume_ls;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    resume_ls_d = 1'b0;
                    pend_d      = ex_redirect;
                    state_d     = MEM_WAIT;
                end else if (ex_redirect) begin
                    // The redirect cycle is itself the flush; the squashed ID
                    // instruction never starts a bubble count.
                    flush_ifid = 1'b1;
                    bubble_ex  = 1'b1;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cnt_d   = CNT_W'(LOAD_LAT - 1);
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                if (mem_busy) begin
                    // Frozen pipe: no bubble issued, count paused.
                    resume_ls_d = 1'b1;
                    pend_d      = ex_redirect;
                    state_d     = MEM_WAIT;
                end else begin
                    bubble_ex = 1'b1;
                    cnt_d     = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                pend_d   = redirect_pend | ex_redirect;
                if (!mem_busy) begin
                    if (redirect_pend | ex_redirect) begin
                        state_d = FLUSH;
                    end else if (resume_ls) begin
                        state_d = LOAD_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
                pend_d     = 1'b0;
                cnt_d      = '0;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        id_stage.vld     = id_valid & ~bubble_ex & ~flush_ifid;
        id_stage.rd      = id_rd;
        id_stage.wen     = id_wen;
        id_stage.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            cnt           <= '0;
            redirect_pend <= 1'b0;
            resume_ls     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            redirect_pend <= pend_d;
            resume_ls     <= resume_ls_d;
        end
    end

    // ID -> EX -> MEM -> WB shadow boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (mem_busy || (stall_id && !bubble_ex)) begin
            // Whole pipe frozen (back-pressure, or the release cycle of MEM_WAIT).
            ex_q  <= ex_q;
            mem_q <= mem_q;
            wb_q  <= wb_q;
        end else begin
            ex_q  <= id_stage;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: one instance with LOAD_LAT = 1 (a) and one
// with LOAD_LAT = 3 (b) share the same stimulus; expectations are queued per step.
module tb_pipe_hazard_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_wen, id_is_load;
    logic       ex_redirect, mem_busy;

    logic       a_si, a_sd, a_bx, a_fl;
    logic [1:0] a_f1, a_f2;
    logic       b_si, b_sd, b_bx, b_fl;
    logic [1:0] b_f1, b_f2;
    logic [7:0] obs_a, obs_b;

    always #5 clk = ~clk;

    pipe_hazard_ctl #(.REG_W(5), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if(a_si), .stall_id(a_sd), .bubble_ex(a_bx), .flush_ifid(a_fl),
        .fwd_rs1_sel(a_f1), .fwd_rs2_sel(a_f2)
    );

    pipe_hazard_ctl #(.REG_W(5), .LOAD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_if(b_si), .stall_id(b_sd), .bubble_ex(b_bx), .flush_ifid(b_fl),
        .fwd_rs1_sel(b_f1), .fwd_rs2_sel(b_f2)
    );

    assign obs_a = {a_si, a_sd, a_bx, a_fl, a_f1, a_f2};
    assign obs_b = {b_si, b_sd, b_bx, b_fl, b_f1, b_f2};

    // {stall_if, stall_id, bubble_ex, flush_ifid, fwd_rs1_sel, fwd_rs2_sel}
    localparam logic [7:0] ALL = 8'hFF;
    localparam logic [7:0] CTL = 8'hF0;
    localparam logic [7:0] CF2 = 8'hF3;

    typedef struct {
        string      tag;
        bit         which;
        logic [7:0] val;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] ov(logic si, logic sd, logic bx, logic fl,
                                      logic [1:0] f1, logic [1:0] f2);
        return {si, sd, bx, fl, f1, f2};
    endfunction

    task automatic expect_out(input string tag, input bit which,
                              input logic [7:0] val, input logic [7:0] mask);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.val   = val;
        e.mask  = mask;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t       e;
        logic [7:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = e.which ? obs_b : obs_a;
            checks++;
            assert ((o & e.mask) === (e.val & e.mask))
            else begin
                errors++;
                $error("FAIL %s: observed %b expected %b (mask %b)",
                       e.tag, o & e.mask, e.val & e.mask, e.mask);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wen, input logic ld);
        id_valid   = v;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
    endtask

    initial begin
        rst         = 1'b0;
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_a", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        expect_out("reset_b", 1, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        rst = 1'b1;
        expect_out("post_reset", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();

        // forwarding EX / MEM / WB
        set_id(1, 1, 1, 2, 1, 5, 1, 0);
        expect_out("add_x5_enter", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        set_id(1, 5, 1, 3, 1, 8, 1, 0);
        expect_out("fwd_ex", 0, ov(0, 0, 0, 0, 2'b01, 2'b00), ALL);
        tick();
        set_id(1, 5, 1, 0, 0, 9, 1, 0);
        expect_out("fwd_mem", 0, ov(0, 0, 0, 0, 2'b10, 2'b00), ALL);
        tick();
        set_id(1, 5, 1, 8, 1, 0, 0, 0);
        expect_out("fwd_wb_and_mem", 0, ov(0, 0, 0, 0, 2'b11, 2'b10), ALL);
        tick();
        set_id(1, 9, 1, 8, 1, 9, 1, 0);
        expect_out("fwd_mem_and_wb", 0, ov(0, 0, 0, 0, 2'b10, 2'b11), ALL);
        tick();
        set_id(1, 9, 1, 9, 0, 0, 0, 0);
        expect_out("fwd_prio_ex_over_wb", 0, ov(0, 0, 0, 0, 2'b01, 2'b00), ALL);
        tick();

        // x0 and read-enable gating, id_valid = 0
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        expect_out("lw_x0_enter", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        set_id(1, 0, 1, 0, 1, 7, 1, 1);
        expect_out("x0_no_hazard", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        set_id(1, 7, 0, 7, 0, 7, 1, 1);
        expect_out("use_rs_gated", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        set_id(0, 7, 1, 7, 1, 0, 0, 0);
        expect_out("invalid_id_no_stall", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        set_id(1, 7, 1, 0, 0, 0, 0, 0);
        expect_out("load_in_mem_fwd", 0, ov(0, 0, 0, 0, 2'b10, 2'b00), ALL);
        tick();

        // load-use with LOAD_LAT = 1
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        expect_out("lw_x6_enter", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        set_id(1, 1, 1, 6, 1, 10, 1, 0);
        expect_out("load_use_stall", 0, ov(1, 1, 1, 0, 2'b00, 2'b00), CTL);
        tick();
        expect_out("load_use_release", 0, ov(0, 0, 0, 0, 2'b00, 2'b10), ALL);
        tick();

        // redirect beats load-use
        set_id(1, 0, 0, 0, 0, 11, 1, 1);
        expect_out("lw_x11_enter", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        set_id(1, 11, 1, 0, 0, 12, 1, 0);
        ex_redirect = 1'b1;
        expect_out("redirect_beats_ldu", 0, ov(0, 0, 1, 1, 2'b00, 2'b00), CTL);
        tick();
        ex_redirect = 1'b0;
        set_id(1, 11, 1, 0, 0, 0, 0, 0);
        expect_out("no_load_stall_after", 0, ov(0, 0, 0, 0, 2'b10, 2'b00), ALL);
        tick();

        // redirect during mem_busy
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        mem_busy = 1'b1;
        expect_out("busy_run", 0, ov(1, 1, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        ex_redirect = 1'b1;
        expect_out("busy_redirect", 0, ov(1, 1, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        mem_busy    = 1'b0;
        ex_redirect = 1'b0;
        expect_out("busy_drop", 0, ov(1, 1, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        expect_out("pending_flush", 0, ov(0, 0, 1, 1, 2'b00, 2'b00), CTL);
        tick();
        expect_out("after_flush", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), CTL);
        tick();

        // back-to-back redirects
        ex_redirect = 1'b1;
        expect_out("redirect_1", 0, ov(0, 0, 1, 1, 2'b00, 2'b00), CTL);
        tick();
        expect_out("redirect_2", 0, ov(0, 0, 1, 1, 2'b00, 2'b00), CTL);
        tick();
        ex_redirect = 1'b0;
        expect_out("redirect_end", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), CTL);
        tick();

        // reset in the middle of a LOAD_LAT = 3 stall
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        set_id(1, 1, 1, 6, 1, 10, 1, 0);
        expect_out("ldu_detect_a", 0, ov(1, 1, 1, 0, 2'b00, 2'b00), CTL);
        expect_out("ldu_detect_b", 1, ov(1, 1, 1, 0, 2'b00, 2'b00), CTL);
        tick();
        expect_out("ldu_done_a", 0, ov(0, 0, 0, 0, 2'b00, 2'b10), CF2);
        expect_out("ldu_stall_b", 1, ov(1, 1, 1, 0, 2'b00, 2'b10), CF2);
        tick();
        rst = 1'b0;
        expect_out("reset_mid_stall_a", 0, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        expect_out("reset_mid_stall_b", 1, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();
        rst = 1'b1;
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset_release_b", 1, ov(0, 0, 0, 0, 2'b00, 2'b00), ALL);
        tick();

        // LOAD_LAT = 3 stall interrupted by 4 cycles of mem_busy
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        expect_out("lat3_lw_enter", 1, ov(0, 0, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        set_id(1, 1, 1, 6, 1, 10, 1, 0);
        expect_out("lat3_detect", 1, ov(1, 1, 1, 0, 2'b00, 2'b00), CTL);
        tick();
        expect_out("lat3_bubble2", 1, ov(1, 1, 1, 0, 2'b00, 2'b10), CF2);
        expect_out("lat1_single_stall", 0, ov(0, 0, 0, 0, 2'b00, 2'b10), CF2);
        tick();
        mem_busy = 1'b1;
        expect_out("lat3_busy_0", 1, ov(1, 1, 0, 0, 2'b00, 2'b11), CF2);
        expect_out("lat1_busy", 0, ov(1, 1, 0, 0, 2'b00, 2'b00), CTL);
        tick();
        for (int i = 1; i < 4; i++) begin
            expect_out($sformatf("lat3_busy_%0d", i), 1, ov(1, 1, 0, 0, 2'b00, 2'b11), CF2);
            tick();
        end
        mem_busy = 1'b0;
        expect_out("lat3_resume", 1, ov(1, 1, 0, 0, 2'b00, 2'b11), CF2);
        tick();
        expect_out("lat3_last_bubble", 1, ov(1, 1, 1, 0, 2'b00, 2'b11), CF2);
        tick();
        expect_out("lat3_done", 1, ov(0, 0, 0, 0, 2'b00, 2'b00), CF2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
